hdmi_rx_frame_sequencer: RTL and testbench
==========================================

// Module: hdmi_rx_frame_sequencer
// PURPOSE
//  Pixel-clock-domain controller for the AXI->HDMI receive path. Sequences the
//  pixel FIFO: reset, wait for a frame-start boundary marker, prefill, delay,
//  then enable the 1080p timing generator. Gates FIFO reads to the RUN state.
//  Detects underflow (pixel request while FIFO empty) and forces a clean resync
//  at the next frame end.
// PARAMETERS
//  RST_CYCLES      8          cycles fifo_rst is held high in FLUSH (1..255)
//  LEVEL_W         11         width of fifo_rd_level (1024-deep FIFO)
//  PREFILL_LEVEL   480        FIFO words required before start-up delay begins
//  START_DELAY     16         cycles from prefill met to timing_en=1 (1..255)
//  TIMEOUT_W       22         width of prefill timeout counter
//  PREFILL_TIMEOUT 2500000    PREFILL cycles before abandon and re-FLUSH (~1 frame)
// PORTS
//  pixel_clk        in   1        pixel clock, 148.5 MHz; only clock
//  rst_n            in   1        asynchronous reset, active low
//  enable           in   1        level; 0 forces IDLE
//  boundary_pulse   in   1        1-cycle frame-start marker, already synced to pixel_clk
//  fifo_empty       in   1        pixel FIFO empty (read side)
//  fifo_rd_level    in   LEVEL_W  pixel FIFO read-side occupancy
//  fifo_rst_busy    in   1        FIFO read-side reset busy
//  pix_req          in   1        timing generator wants a pixel this cycle (DE window)
//  frame_end        in   1        1-cycle pulse on last pixel-clock of frame
//  fifo_rst         out  1        FIFO reset request
//  timing_en        out  1        timing generator enable (counters run when 1)
//  rd_gate          out  1        permits FIFO rd_en (rd_en = pix_req & rd_gate & !fifo_empty)
//  locked           out  1        1 while in RUN
//  state            out  3        current state encoding (debug/ILA)
//  underflow_cnt    out  16       saturating count of underflow cycles
//  resync_cnt       out  8        saturating count of forced re-FLUSHes
// BEHAVIOUR
//  Reset: state=IDLE, fifo_rst=1, timing_en=0, rd_gate=0, locked=0, counters=0.
//  All outputs registered; they reflect the state one cycle after a transition.
//  States: IDLE=0 FLUSH=1 RSTWAIT=2 WAIT_MARK=3 PREFILL=4 DELAY=5 RUN=6.
//  Priority: enable=0 in any state -> IDLE next cycle, overriding all else.
//  IDLE: fifo_rst=1; enable=1 -> FLUSH.
//  FLUSH: fifo_rst=1 for exactly RST_CYCLES cycles, then -> RSTWAIT.
//  RSTWAIT: fifo_rst=0; fifo_rst_busy=0 -> WAIT_MARK. Boundary pulses ignored.
//  WAIT_MARK: boundary_pulse -> PREFILL; no timeout.
//  PREFILL: fifo_rd_level >= PREFILL_LEVEL -> DELAY. Timeout counter reaches
//   PREFILL_TIMEOUT first -> FLUSH and resync_cnt+1. Level met and timeout in the
//   same cycle -> DELAY.
//  DELAY: START_DELAY cycles -> RUN. timing_en rises on the first RUN cycle.
//  RUN: timing_en=1, rd_gate=1, locked=1. boundary_pulse ignored.
//   Each cycle with pix_req & fifo_empty: underflow_cnt+1 (saturate 0xFFFF) and
//   set uf_pending. On frame_end with uf_pending set (including underflow in the
//   same cycle): -> FLUSH, resync_cnt+1 (saturate 0xFF), clear uf_pending.
//   timing_en/rd_gate/locked drop with that transition, so the partial frame ends
//   at a frame boundary.
//  Outside RUN: rd_gate=0, timing_en=0, locked=0. uf_pending is cleared on any
//   RUN exit.
//  Counters clear only on rst_n; they hold through IDLE.
//  Reset asserted mid-frame: outputs take reset values immediately (async).
// TESTING
//  1 enable=1, busy low, boundary_pulse at t0, level steps to 480 at t0+100 ->
//    fifo_rst high exactly 8 cycles; timing_en=1, locked=1 16 cycles after level met.
//  2 In RUN, fifo_empty=1 with pix_req for 3 cycles mid-frame -> underflow_cnt=3,
//    stays RUN until frame_end, then state=FLUSH, resync_cnt=1, timing_en=0.
//  3 PREFILL with level stuck at 100 (PREFILL_TIMEOUT=1000 in bench) ->
//    FLUSH after 1000 cycles, resync_cnt=1, then waits for a new boundary_pulse.
//  4 enable deasserted in DELAY and in RUN -> IDLE next cycle, fifo_rst=1,
//    timing_en=0; re-enable restarts from FLUSH.
//  5 fifo_rst_busy held high 50 cycles after FLUSH, boundary_pulse during it ->
//    pulse ignored; WAIT_MARK entered only after busy falls.
//  6 Force 0xFFFF underflow cycles -> underflow_cnt saturates at 0xFFFF, no wrap;
//    async rst_n low mid-RUN -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/hdmi_rx_frame_sequencer_if.sv
// Signal bundle between the HDMI RX frame sequencer and its pixel FIFO / timing generator.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface hdmi_rx_frame_sequencer_if #(
  parameter int LEVEL_W = 11
);
  logic               enable;
  logic               boundary_pulse;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_rd_level;
  logic               fifo_rst_busy;
  logic               pix_req;
  logic               frame_end;

  logic               fifo_rst;
  logic               timing_en;
  logic               rd_gate;
  logic               locked;
  logic [2:0]         state;
  logic [15:0]        underflow_cnt;
  logic [7:0]         resync_cnt;

  modport master (
    input  enable, boundary_pulse, fifo_empty, fifo_rd_level, fifo_rst_busy,
           pix_req, frame_end,
    output fifo_rst, timing_en, rd_gate, locked, state, underflow_cnt, resync_cnt
  );

  modport slave (
    output enable, boundary_pulse, fifo_empty, fifo_rd_level, fifo_rst_busy,
           pix_req, frame_end,
    input  fifo_rst, timing_en, rd_gate, locked, state, underflow_cnt, resync_cnt
  );
endinterface

// File: rtl/hdmi_rx_frame_sequencer.sv
// Pixel-clock sequencer for the HDMI RX FIFO: flush, mark sync, prefill, delay, run,
// with underflow detection that forces a resync at the next frame end.
module hdmi_rx_frame_sequencer #(
  parameter int RST_CYCLES      = 8,
  parameter int LEVEL_W         = 11,
  parameter int PREFILL_LEVEL   = 480,
  parameter int START_DELAY     = 16,
  parameter int TIMEOUT_W       = 22,
  parameter int PREFILL_TIMEOUT = 2500000
) (
  input  logic                     pixel_clk,
  input  logic                     rst_n,
  hdmi_rx_frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLUSH     = 3'd1,
    S_RSTWAIT   = 3'd2,
    S_WAIT_MARK = 3'd3,
    S_PREFILL   = 3'd4,
    S_DELAY     = 3'd5,
    S_RUN       = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           dly_cnt_q, dly_cnt_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 uf_pending_q, uf_pending_d;
  logic [15:0]          underflow_cnt_q, underflow_cnt_d;
  logic [7:0]           resync_cnt_q, resync_cnt_d;
  logic                 fifo_rst_q, fifo_rst_d;
  logic                 timing_en_q, timing_en_d;
  logic                 rd_gate_q, rd_gate_d;
  logic                 locked_q, locked_d;

  logic                 level_met;
  logic                 underflow_now;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign level_met     = (bus.fifo_rd_level >= LEVEL_W'(PREFILL_LEVEL));
  assign underflow_now = bus.pix_req & bus.fifo_empty;

  always_comb begin
    state_d         = state_q;
    dly_cnt_d       = dly_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    uf_pending_d    = uf_pending_q;
    underflow_cnt_d = underflow_cnt_q;
    resync_cnt_d    = resync_cnt_q;

    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_FLUSH;

        S_FLUSH: begin
          if (dly_cnt_q == 8'(RST_CYCLES - 1)) state_d = S_RSTWAIT;
          else                                 dly_cnt_d = dly_cnt_q + 8'd1;
        end

        S_RSTWAIT: if (!bus.fifo_rst_busy) state_d = S_WAIT_MARK;

        S_WAIT_MARK: if (bus.boundary_pulse) state_d = S_PREFILL;

        // Level check wins over a timeout expiring in the same cycle.
        S_PREFILL: begin
          if (level_met) begin
            state_d = S_DELAY;
          end else if (tmo_cnt_q == TIMEOUT_W'(PREFILL_TIMEOUT - 1)) begin
            state_d      = S_FLUSH;
            resync_cnt_d = sat_inc8(resync_cnt_q);
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end

        S_DELAY: begin
          if (dly_cnt_q == 8'(START_DELAY - 1)) state_d = S_RUN;
          else                                  dly_cnt_d = dly_cnt_q + 8'd1;
        end

        S_RUN: begin
          if (underflow_now) begin
            underflow_cnt_d = sat_inc16(underflow_cnt_q);
            uf_pending_d    = 1'b1;
          end
          if (bus.frame_end && (uf_pending_q || underflow_now)) begin
            state_d      = S_FLUSH;
            resync_cnt_d = sat_inc8(resync_cnt_q);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Every state entry starts its cycle counters from zero.
    if (state_d != state_q) begin
      dly_cnt_d = '0;
      tmo_cnt_d = '0;
    end
    if (state_d != S_RUN) uf_pending_d = 1'b0;

    fifo_rst_d  = (state_d == S_IDLE) || (state_d == S_FLUSH);
    timing_en_d = (state_d == S_RUN);
    rd_gate_d   = (state_d == S_RUN);
    locked_d    = (state_d == S_RUN);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      dly_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      uf_pending_q    <= 1'b0;
      underflow_cnt_q <= '0;
      resync_cnt_q    <= '0;
      fifo_rst_q      <= 1'b1;
      timing_en_q     <= 1'b0;
      rd_gate_q       <= 1'b0;
      locked_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      dly_cnt_q       <= dly_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      uf_pending_q    <= uf_pending_d;
      underflow_cnt_q <= underflow_cnt_d;
      resync_cnt_q    <= resync_cnt_d;
      fifo_rst_q      <= fifo_rst_d;
      timing_en_q     <= timing_en_d;
      rd_gate_q       <= rd_gate_d;
      locked_q        <= locked_d;
    end
  end

  assign bus.fifo_rst      = fifo_rst_q;
  assign bus.timing_en     = timing_en_q;
  assign bus.rd_gate       = rd_gate_q;
  assign bus.locked        = locked_q;
  assign bus.state         = state_q;
  assign bus.underflow_cnt = underflow_cnt_q;
  assign bus.resync_cnt    = resync_cnt_q;

endmodule

// File: tb/tb_hdmi_rx_frame_sequencer.sv
// Bench for hdmi_rx_frame_sequencer: directed scenarios plus random traffic, every cycle
// compared against a countdown-based behavioural model of the sequencing rules.
module tb_hdmi_rx_frame_sequencer;

  localparam int RST_C   = 8;
  localparam int PRE_LVL = 480;
  localparam int DLY     = 16;
  localparam int TMO     = 1000;

  localparam logic [2:0] M_IDLE = 3'd0, M_FLUSH = 3'd1, M_RSTWAIT = 3'd2, M_WAITM = 3'd3,
                         M_PREFILL = 3'd4, M_DELAY = 3'd5, M_RUN = 3'd6;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   chk_on;

  hdmi_rx_frame_sequencer_if #(.LEVEL_W(11)) bus ();

  hdmi_rx_frame_sequencer #(
    .RST_CYCLES(RST_C), .LEVEL_W(11), .PREFILL_LEVEL(PRE_LVL), .START_DELAY(DLY),
    .TIMEOUT_W(22), .PREFILL_TIMEOUT(TMO)
  ) dut (
    .pixel_clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: current state, cycles left in a timed state, counters, pending underflow.
  typedef struct packed {
    logic [2:0] st;
    int         left;
    int         uf;
    int         rs;
    logic       pend;
  } model_t;

  model_t m;

  function automatic int sat(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  function automatic model_t next_model(input model_t c, input logic en, input logic bp,
                                        input logic emp, input logic busy, input logic req,
                                        input logic fe, input int lvl);
    model_t n;
    n = c;
    if (!en) begin
      n.st   = M_IDLE;
      n.pend = 1'b0;
      return n;
    end
    case (c.st)
      M_IDLE: begin n.st = M_FLUSH; n.left = RST_C; end
      M_FLUSH: begin
        n.left = c.left - 1;
        if (n.left == 0) n.st = M_RSTWAIT;
      end
      M_RSTWAIT: if (!busy) n.st = M_WAITM;
      M_WAITM: if (bp) begin n.st = M_PREFILL; n.left = TMO; end
      M_PREFILL: begin
        if (lvl >= PRE_LVL) begin
          n.st = M_DELAY; n.left = DLY;
        end else begin
          n.left = c.left - 1;
          if (n.left == 0) begin n.st = M_FLUSH; n.left = RST_C; n.rs = sat(c.rs, 255); end
        end
      end
      M_DELAY: begin
        n.left = c.left - 1;
        if (n.left == 0) n.st = M_RUN;
      end
      M_RUN: begin
        if (req && emp) begin n.uf = sat(c.uf, 65535); n.pend = 1'b1; end
        if (fe && n.pend) begin
          n.st = M_FLUSH; n.left = RST_C; n.rs = sat(c.rs, 255); n.pend = 1'b0;
        end
      end
      default: n.st = M_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= next_model(m, bus.enable, bus.boundary_pulse, bus.fifo_empty, bus.fifo_rst_busy,
                         bus.pix_req, bus.frame_end, int'(bus.fifo_rd_level));
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic exp_rst, exp_run;
      exp_rst = (m.st == M_IDLE) || (m.st == M_FLUSH);
      exp_run = (m.st == M_RUN);
      checks++;
      if (bus.state !== m.st || bus.fifo_rst !== exp_rst || bus.timing_en !== exp_run ||
          bus.rd_gate !== exp_run || bus.locked !== exp_run ||
          bus.underflow_cnt !== m.uf[15:0] || bus.resync_cnt !== m.rs[7:0]) begin
        failures++;
        $display("FAIL model_cmp t=%0t got st=%0d rst=%b ten=%b gate=%b lock=%b uf=%0d rs=%0d exp st=%0d rst=%b run=%b uf=%0d rs=%0d",
                 $time, bus.state, bus.fifo_rst, bus.timing_en, bus.rd_gate, bus.locked,
                 bus.underflow_cnt, bus.resync_cnt, m.st, exp_rst, exp_run, m.uf, m.rs);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
    int n;
    n = 0;
    while (bus.state !== s && n < max_cyc) begin tick(); n++; end
    if (bus.state !== s) check(name, bus.state, s);
  endtask

  task automatic count_state(input logic [2:0] s, input int max_cyc, output int n);
    n = 0;
    while (bus.state === s && n < max_cyc) begin tick(); n++; end
  endtask

  task automatic pulse_boundary();
    bus.boundary_pulse = 1'b1;
    tick();
    bus.boundary_pulse = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    bit lvl_hi;
    checks   = 0;
    failures = 0;
    chk_on   = 1'b0;
    rst_n    = 1'b0;
    bus.enable = 1'b0; bus.boundary_pulse = 1'b0; bus.fifo_empty = 1'b0;
    bus.fifo_rd_level = '0; bus.fifo_rst_busy = 1'b0; bus.pix_req = 1'b0; bus.frame_end = 1'b0;

    repeat (3) tick();
    check("reset_fifo_rst", bus.fifo_rst, 1);
    check("reset_timing_en", bus.timing_en, 0);
    check("reset_state", bus.state, 0);
    check("reset_counters", {bus.underflow_cnt, bus.resync_cnt}, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    tick();

    // Startup: flush length and delay from prefill to timing enable.
    bus.enable = 1'b1;
    wait_state(M_FLUSH, 5, "t1_reach_flush");
    count_state(M_FLUSH, 50, n);
    check("t1_flush_cycles", n, 8);
    check("t1_fifo_rst_low_after_flush", bus.fifo_rst, 0);
    wait_state(M_WAITM, 10, "t1_reach_waitmark");
    bus.fifo_rd_level = 11'd50;
    pulse_boundary();
    for (int i = 0; i < 99; i++) begin
      bus.fifo_rd_level = 11'($urandom_range(0, 479));
      bus.pix_req = 1'($urandom_range(0, 1));
      tick();
    end
    check("t1_still_prefill", bus.state, M_PREFILL);
    bus.pix_req = 1'b0;
    bus.fifo_rd_level = 11'd480;
    n = 0;
    while (!bus.timing_en && n < 100) begin tick(); if (!bus.timing_en) n++; end
    check("t1_level_to_timing_en", n, 16);
    check("t1_locked", bus.locked, 1);

    // Underflow mid-frame, resync at frame end.
    bus.fifo_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin bus.pix_req = 1'($urandom_range(0, 1)); tick(); end
    bus.pix_req = 1'b1; bus.fifo_empty = 1'b1;
    repeat (3) tick();
    bus.fifo_empty = 1'b0;
    repeat (10) tick();
    check("t2_underflow_cnt", bus.underflow_cnt, 3);
    check("t2_still_run", bus.state, M_RUN);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0; bus.pix_req = 1'b0;
    check("t2_state_flush", bus.state, M_FLUSH);
    check("t2_resync_cnt", bus.resync_cnt, 1);
    check("t2_timing_en_low", bus.timing_en, 0);

    // Prefill timeout.
    wait_state(M_WAITM, 50, "t3_reach_waitmark");
    bus.fifo_rd_level = 11'd100;
    pulse_boundary();
    count_state(M_PREFILL, 3000, n);
    check("t3_prefill_cycles", n, 1000);
    check("t3_state_flush", bus.state, M_FLUSH);
    check("t3_resync_cnt", bus.resync_cnt, 2);
    wait_state(M_WAITM, 50, "t3_back_waitmark");
    repeat (50) tick();
    check("t3_waits_for_mark", bus.state, M_WAITM);

    // Enable drop in DELAY and in RUN.
    bus.fifo_rd_level = 11'd600;
    pulse_boundary();
    tick();
    repeat (5) tick();
    check("t4_in_delay", bus.state, M_DELAY);
    bus.enable = 1'b0;
    tick();
    check("t4_delay_to_idle", bus.state, M_IDLE);
    check("t4_idle_fifo_rst", bus.fifo_rst, 1);
    bus.enable = 1'b1;
    tick();
    check("t4_restart_flush", bus.state, M_FLUSH);
    wait_state(M_WAITM, 50, "t4_reach_waitmark");
    pulse_boundary();
    wait_state(M_RUN, 50, "t4_reach_run");
    bus.enable = 1'b0;
    tick();
    check("t4_run_to_idle", bus.state, M_IDLE);
    check("t4_run_drop_timing_en", bus.timing_en, 0);

    // Busy held after flush; boundary during busy is ignored.
    bus.enable = 1'b1; bus.fifo_rst_busy = 1'b1;
    tick();
    check("t5_restart_flush", bus.state, M_FLUSH);
    wait_state(M_RSTWAIT, 50, "t5_reach_rstwait");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      bus.boundary_pulse = (i == 20);
      tick();
      if (bus.state !== M_RSTWAIT) bad++;
    end
    bus.boundary_pulse = 1'b0;
    check("t5_held_in_rstwait", bad, 0);
    bus.fifo_rst_busy = 1'b0;
    tick();
    check("t5_waitmark_after_busy", bus.state, M_WAITM);
    repeat (5) tick();
    check("t5_pulse_was_ignored", bus.state, M_WAITM);

    // Underflow saturation, then asynchronous reset mid-RUN.
    pulse_boundary();
    wait_state(M_RUN, 50, "t6_reach_run");
    bus.pix_req = 1'b1; bus.fifo_empty = 1'b1;
    repeat (65540) tick();
    check("t6_underflow_saturated", bus.underflow_cnt, 16'hFFFF);
    check("t6_still_run", bus.state, M_RUN);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_fifo_rst", bus.fifo_rst, 1);
    check("t6_async_timing_en", bus.timing_en, 0);
    check("t6_async_rd_gate", bus.rd_gate, 0);
    check("t6_async_locked", bus.locked, 0);
    check("t6_async_state", bus.state, 0);
    check("t6_async_underflow_cnt", bus.underflow_cnt, 0);
    check("t6_async_resync_cnt", bus.resync_cnt, 0);
    bus.pix_req = 1'b0; bus.fifo_empty = 1'b0;
    tick();
    rst_n = 1'b1;

    // Random traffic against the model.
    lvl_hi = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) lvl_hi = 1'($urandom_range(0, 1));
      bus.enable         = ($urandom_range(0, 299) != 0);
      bus.boundary_pulse = ($urandom_range(0, 39) == 0);
      bus.fifo_rst_busy  = ($urandom_range(0, 3) == 0);
      bus.fifo_rd_level  = lvl_hi ? 11'($urandom_range(470, 2047)) : 11'($urandom_range(0, 479));
      bus.pix_req        = 1'($urandom_range(0, 1));
      bus.fifo_empty     = ($urandom_range(0, 19) == 0);
      bus.frame_end      = ($urandom_range(0, 59) == 0);
      tick();
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
